// File: rtl/audiodac_pkg.sv
// audiodac_pkg: shared types and constants for the audio DAC delta-sigma stage.
// Holds the FSM state type, OSR lookup, full-scale / saturation helpers and
// the dither LFSR constants used when AUDIODAC_SDM_DITHER_EN is defined.
package audiodac_pkg;

  // Modulator control states
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } sdm_state_e;

  // Feedback magnitude: one LSB of the 1-bit DAC equals +/-2^15
  localparam int FS = 32768;

  // Default integrator width and its saturation limits
  localparam int IW_DEFAULT = 20;
  localparam longint IW_SAT_MAX = (longint'(1) <<< (IW_DEFAULT - 1)) - 1;
  localparam longint IW_SAT_MIN = -(longint'(1) <<< (IW_DEFAULT - 1));

  // Dither LFSR (16-bit Galois, right-shifting)
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Largest value of a signed w-bit integer
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value of a signed w-bit integer
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Terminal count of the OSR counter (OSR-1) for each osr_sel code
  function automatic logic [7:0] osr_last(input logic [1:0] sel);
    logic [7:0] r;
    case (sel)
      2'b00:   r = 8'd31;
      2'b01:   r = 8'd63;
      2'b10:   r = 8'd127;
      default: r = 8'd255;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/audiodac_sdm_lfsr.sv
// audiodac_sdm_lfsr: 16-bit Galois LFSR producing 2-bit signed dither.
// Only instantiated when AUDIODAC_SDM_DITHER_EN is defined. Returns to the
// seed on reset and whenever the modulator is switched off, so a restarted
// run reproduces the same dither sequence.
module audiodac_sdm_lfsr
  import audiodac_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       clear,
  input  logic       advance,
  output logic [1:0] dither_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR state: reseed on clear, one Galois step per modulator tick
  always_comb begin
    lfsr_d = lfsr_q;
    if (clear) begin
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
    end
  end

  // LFSR register, reset to the seed
  always_ff @(posedge clk) begin
    if (srst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign dither_o = lfsr_q[1:0];

endmodule

// File: rtl/audiodac_sdm.sv
// audiodac_sdm: 16-bit signed PCM -> complementary 1-bit delta-sigma pulse pair.
// Zero-order-hold oversampling (OSR 32..256) feeding a 2nd-order CIFB modulator
// whose tick rate is set by clk_div. One-entry sample buffer ahead of the
// hold register; a sticky underflow flag reports a missing sample at the
// sample-period boundary.
// Build option: define AUDIODAC_SDM_DITHER_EN to add 2-bit LFSR dither to the
// modulator input; left undefined the modulator is exactly the plain CIFB loop.
module audiodac_sdm
  import audiodac_pkg::*;
#(
  parameter int DW   = 16,
  parameter int IW   = 20,
  parameter int DIVW = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            enable,
  input  logic            mute,
  input  logic [1:0]      osr_sel,
  input  logic [DIVW-1:0] clk_div,
  input  logic [DW-1:0]   sample_i,
  input  logic            sample_valid,
  output logic            sample_ready,
  output logic            ds_p,
  output logic            ds_n,
  output logic            underflow,
  input  logic            underflow_clr
);

  // Arithmetic is done two bits wider than the integrators so that the
  // clamp sees the true sum before it can wrap.
  localparam int WW = IW + 2;
  localparam logic signed [IW-1:0] I_MAX = IW'(sat_max(IW));
  localparam logic signed [IW-1:0] I_MIN = IW'(sat_min(IW));
  localparam logic signed [WW-1:0] W_MAX = WW'(sat_max(IW));
  localparam logic signed [WW-1:0] W_MIN = WW'(sat_min(IW));
  localparam logic signed [WW-1:0] FS_W  = WW'(FS);

  // Clamp a wide sum into the integrator range
  function automatic logic signed [IW-1:0] sat(input logic signed [WW-1:0] v);
    logic signed [IW-1:0] r;
    if (v > W_MAX) begin
      r = I_MAX;
    end else if (v < W_MIN) begin
      r = I_MIN;
    end else begin
      r = IW'(v);
    end
    return r;
  endfunction

  sdm_state_e              state_q, state_d;
  logic [DIVW-1:0]         div_cnt_q, div_cnt_d;
  logic [DIVW-1:0]         clk_div_q, clk_div_d;
  logic [7:0]              osr_cnt_q, osr_cnt_d;
  logic [7:0]              osr_last_q, osr_last_d;
  logic signed [DW-1:0]    hold_q, hold_d;
  logic [DW-1:0]           buf_data_q, buf_data_d;
  logic                    buf_full_q, buf_full_d;
  logic signed [IW-1:0]    i1_q, i1_d;
  logic signed [IW-1:0]    i2_q, i2_d;
  logic                    ds_p_q, ds_p_d;
  logic                    ds_n_q, ds_n_d;
  logic                    underflow_q, underflow_d;

  logic                    tick;
  logic                    wrap;
  logic                    accept;
  logic                    uf_evt;
  logic                    sample_ready_w;
  logic signed [WW-1:0]    dith_w;
  logic signed [WW-1:0]    x_w;
  logic signed [WW-1:0]    y_w;
  logic signed [WW-1:0]    i1_sum;
  logic signed [WW-1:0]    i2_sum;
  logic signed [IW-1:0]    i1_sat;
  logic signed [IW-1:0]    i2_sat;

`ifdef AUDIODAC_SDM_DITHER_EN
  logic [1:0] dither_bits;

  audiodac_sdm_lfsr u_lfsr (
    .clk      (wb_clk_i),
    .srst     (wb_rst_i),
    .clear    (state_q == ST_OFF),
    .advance  (tick),
    .dither_o (dither_bits)
  );

  // Two LSBs read as a signed value in -2..1
  assign dith_w = WW'($signed(dither_bits));
`else
  assign dith_w = '0;
`endif

  assign sample_ready_w = (state_q != ST_OFF) && !buf_full_q;
  assign accept         = sample_valid && sample_ready_w;
  assign tick           = (state_q == ST_RUN) && (div_cnt_q == clk_div_q);
  assign wrap           = tick && (osr_cnt_q == osr_last_q);

  // Modulator datapath: integrator updates for the current tick (i2 uses old i1)
  always_comb begin
    x_w = WW'(hold_q);
    if (mute) begin
      x_w = '0;
    end
    x_w    = x_w + dith_w;
    y_w    = ds_p_q ? FS_W : -FS_W;
    i1_sum = WW'(i1_q) + x_w - y_w;
    i2_sum = WW'(i2_q) + WW'(i1_q) - y_w;
    i1_sat = sat(i1_sum);
    i2_sat = sat(i2_sum);
  end

  // Control: FSM, tick divider, OSR counter, buffer/hold handoff, underflow
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    clk_div_d   = clk_div_q;
    osr_cnt_d   = osr_cnt_q;
    osr_last_d  = osr_last_q;
    hold_d      = hold_q;
    buf_data_d  = buf_data_q;
    buf_full_d  = buf_full_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    ds_p_d      = ds_p_q;
    ds_n_d      = ds_n_q;
    uf_evt      = 1'b0;

    if (!enable) begin
      // Switched off: clear the datapath, keep only the sticky flag.
      state_d    = ST_OFF;
      div_cnt_d  = '0;
      osr_cnt_d  = '0;
      clk_div_d  = clk_div;
      osr_last_d = osr_last(osr_sel);
      hold_d     = '0;
      buf_data_d = '0;
      buf_full_d = 1'b0;
      i1_d       = '0;
      i2_d       = '0;
      ds_p_d     = 1'b0;
      ds_n_d     = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d    = ST_FILL;
          clk_div_d  = clk_div;
          osr_last_d = osr_last(osr_sel);
        end
        ST_FILL: begin
          clk_div_d  = clk_div;
          osr_last_d = osr_last(osr_sel);
          // The first sample bypasses the buffer and starts the first period.
          if (accept) begin
            hold_d    = sample_i;
            div_cnt_d = '0;
            osr_cnt_d = '0;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            div_cnt_d = '0;
            clk_div_d = clk_div;
            i1_d      = i1_sat;
            i2_d      = i2_sat;
            ds_p_d    = ~i2_sat[IW-1];
            ds_n_d    = i2_sat[IW-1];
            if (wrap) begin
              osr_cnt_d  = '0;
              osr_last_d = osr_last(osr_sel);
              if (buf_full_q) begin
                hold_d     = buf_data_q;
                buf_full_d = 1'b0;
              end else begin
                uf_evt = 1'b1;
              end
            end else begin
              osr_cnt_d = osr_cnt_q + 8'd1;
            end
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
          // Applied after the wrap drain so a same-cycle accept is never lost.
          if (accept) begin
            buf_data_d = sample_i;
            buf_full_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end

    // A new underflow event beats a simultaneous clear.
    underflow_d = (underflow_q & ~underflow_clr) | uf_evt;
  end

  // State registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_OFF;
      div_cnt_q   <= '0;
      clk_div_q   <= '0;
      osr_cnt_q   <= '0;
      osr_last_q  <= '0;
      hold_q      <= '0;
      buf_data_q  <= '0;
      buf_full_q  <= 1'b0;
      i1_q        <= '0;
      i2_q        <= '0;
      ds_p_q      <= 1'b0;
      ds_n_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      clk_div_q   <= clk_div_d;
      osr_cnt_q   <= osr_cnt_d;
      osr_last_q  <= osr_last_d;
      hold_q      <= hold_d;
      buf_data_q  <= buf_data_d;
      buf_full_q  <= buf_full_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      ds_p_q      <= ds_p_d;
      ds_n_q      <= ds_n_d;
      underflow_q <= underflow_d;
    end
  end

  assign sample_ready = sample_ready_w;
  assign ds_p         = ds_p_q;
  assign ds_n         = ds_n_q;
  assign underflow    = underflow_q;

endmodule
